// File: rtl/palette_reader.sv
// Palette lookup stage: drives the palette RAM address from a valid/ready index stream,
// realigns the one-cycle registered read and buffers results in a 2-entry skid FIFO.
module palette_reader #(
    parameter int ram_width  = 8,
    parameter int data_width = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ram_width-1:0]  in_index,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ram_width-1:0]  rd_add,
    input  logic [data_width-1:0] rd_data,
    output logic [data_width-1:0] out_pixel,
    output logic                  out_transparent,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           transparent_count,
    output logic [15:0]           line_count
);

    // FIFO entry layout: {colour, transparent, last}
    localparam int EW = data_width + 2;

    logic          r_s1_valid;
    logic          r_s1_last;
    logic [EW-1:0] r_fifo [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;
    logic [15:0]   r_tcount;
    logic [15:0]   r_lcount;

    logic          w_accept;
    logic          w_pop;
    logic          w_push;
    logic [2:0]    w_occ;
    logic [EW-1:0] w_entry;
    logic [EW-1:0] w_head;

    assign rd_add    = in_index;
    assign out_valid = (r_count != 2'd0);
    assign w_pop     = out_valid && out_ready;
    assign w_push    = r_s1_valid;

    // Occupancy after this edge: buffered + in flight - leaving. Admit only if a slot remains.
    assign w_occ    = {1'b0, r_count} + {2'b00, r_s1_valid} - {2'b00, w_pop};
    assign in_ready = (w_occ < 3'd2);
    assign w_accept = in_valid && in_ready;

    assign w_entry = {rd_data, (rd_data == '0), r_s1_last};
    assign w_head  = r_fifo[r_rd_ptr];

    assign out_pixel         = out_valid ? w_head[EW-1:2] : '0;
    assign out_transparent   = out_valid ? w_head[1] : 1'b0;
    assign out_last          = out_valid ? w_head[0] : 1'b0;
    assign transparent_count = r_tcount;
    assign line_count        = r_lcount;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_tcount   <= 16'd0;
            r_lcount   <= 16'd0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_last <= in_last;
            end
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_pop && out_transparent && (r_tcount != 16'hFFFF)) begin
                r_tcount <= r_tcount + 16'd1;
            end
            if (w_pop && out_last) begin
                r_lcount <= r_lcount + 16'd1;
            end
        end
    end

    // Storage needs no reset: the head is masked by out_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_entry;
        end
    end

endmodule

// File: tb/tb_palette_reader.sv
// Bench for palette_reader: behavioural RAM, queue-based reference model checked every
// cycle on the falling edge, plus directed literal checks.
module tb_palette_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_index = 8'd0;
    logic        in_last = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  rd_add;
    logic [11:0] rd_data = 12'd0;
    logic [11:0] out_pixel;
    logic        out_transparent;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] transparent_count;
    logic [15:0] line_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic rand_mode = 1'b0;
    logic or_fixed = 1'b1;

    // Expected beat: {available_cycle[31:0], last, transparent, pixel[11:0]}
    localparam int W = 46;
    logic [W-1:0] exp_q[$];
    logic [15:0]  m_tc = 16'd0;
    logic [15:0]  m_lc = 16'd0;
    logic         prev_stall = 1'b0;
    logic [13:0]  prev_out = 14'd0;
    logic [11:0]  pal [256];

    palette_reader #(.ram_width(8), .data_width(12)) dut (
        .clk(clk), .rst(rst),
        .in_index(in_index), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .rd_add(rd_add), .rd_data(rd_data),
        .out_pixel(out_pixel), .out_transparent(out_transparent), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .transparent_count(transparent_count), .line_count(line_count)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) begin
            pal[i] = (i == 4 || i == 51 || i == 53 || i == 103) ? 12'h000 : 12'(i);
        end
    end

    // Palette RAM: one-cycle registered read
    always @(posedge clk) rd_data <= pal[rd_add];
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = rand_mode ? 1'($urandom_range(0, 1)) : or_fixed;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model and per-cycle comparison
    always @(negedge clk) begin : model
        logic         e_valid;
        logic         e_pop;
        logic         e_ready;
        logic [W-1:0] h;
        if (rst) begin
            exp_q.delete();
            m_tc = 16'd0;
            m_lc = 16'd0;
            prev_stall = 1'b0;
        end else begin
            h = '0;
            e_valid = 1'b0;
            if (exp_q.size() != 0) begin
                h = exp_q[0];
                e_valid = (int'(h[45:14]) <= cyc);
            end
            e_pop = e_valid && out_ready;
            e_ready = ((exp_q.size() - (e_pop ? 1 : 0)) < 2);
            chk("out_valid", 32'(out_valid), 32'(e_valid));
            chk("in_ready", 32'(in_ready), 32'(e_ready));
            chk("transparent_count", 32'(transparent_count), 32'(m_tc));
            chk("line_count", 32'(line_count), 32'(m_lc));
            if (prev_stall) begin
                chk("stall_hold", 32'({out_pixel, out_transparent, out_last}), 32'(prev_out));
            end
            if (e_valid && out_valid) begin
                chk("out_pixel", 32'(out_pixel), 32'(h[11:0]));
                chk("out_transparent", 32'(out_transparent), 32'(h[12]));
                chk("out_last", 32'(out_last), 32'(h[13]));
            end
            if (e_pop) begin
                void'(exp_q.pop_front());
                if (h[12] && m_tc != 16'hFFFF) m_tc = m_tc + 16'd1;
                if (h[13]) m_lc = m_lc + 16'd1;
            end
            if (in_valid && e_ready) begin
                exp_q.push_back({32'(cyc + 2), in_last, (pal[in_index] == 12'h000), pal[in_index]});
            end
            prev_stall = out_valid && !out_ready;
            prev_out = {out_pixel, out_transparent, out_last};
        end
    end

    // Present one beat and hold it until accepted; returns at posedge+1.
    task automatic push_beat(input logic [7:0] idx, input logic last);
        int  waits = 0;
        bit  done = 0;
        in_valid = 1'b1;
        in_index = idx;
        in_last = last;
        while (!done) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                done = 1;
            end else begin
                waits++;
                if (waits > 1000) begin
                    total++;
                    bad++;
                    $display("FAIL accept_timeout: idx %0d not accepted in 1000 cycles", idx);
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        in_last = 1'b0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d beats still pending", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int acc;
        logic a;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_pixel", 32'(out_pixel), 32'd0);
        chk("rst_out_transparent", 32'(out_transparent), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_tcount", 32'(transparent_count), 32'd0);
        chk("rst_lcount", 32'(line_count), 32'd0);
        @(posedge clk);
        #1;

        // Single beat latency: visible two clocks after the accept edge
        push_beat(8'd9, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_first_cycle", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lat_second_cycle", 32'(out_valid), 32'd1);
        chk("lat_pixel", 32'(out_pixel), 32'h009);
        @(posedge clk);
        #1;

        // Full palette sweep at full rate
        for (int i = 0; i < 256; i++) push_beat(8'(i), 1'b0);
        drain();
        @(negedge clk);
        chk("sweep_tcount", 32'(transparent_count), 32'd5);
        @(posedge clk);
        #1;

        // Back-pressure: only two beats fit, release reopens input at once
        or_fixed = 1'b0;
        @(posedge clk);
        #1;
        acc = 0;
        in_valid = 1'b1;
        in_index = 8'd10;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            a = in_ready;
            @(posedge clk);
            #1;
            if (a) begin
                acc++;
                in_index = in_index + 8'd1;
            end
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        or_fixed = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        drain();

        // Random back-pressure with random indices
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) push_beat(8'($urandom_range(0, 255)), 1'b0);
        rand_mode = 1'b0;
        drain();

        // Three 640-pixel lines
        for (int i = 0; i < 1920; i++) push_beat(8'(i % 256), (i % 640) == 639);
        drain();
        @(negedge clk);
        chk("line_count_3", 32'(line_count), 32'd3);
        @(posedge clk);
        #1;

        // Saturation of the transparent counter
        for (int i = 0; i < 70000; i++) push_beat(8'd4, 1'b0);
        drain();
        @(negedge clk);
        chk("tcount_saturated", 32'(transparent_count), 32'hFFFF);
        @(posedge clk);
        #1;

        // Reset with two beats buffered
        or_fixed = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_index = 8'd7;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        or_fixed = 1'b1;
        @(negedge clk);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_tcount", 32'(transparent_count), 32'd0);
        chk("post_rst_lcount", 32'(line_count), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_rst_no_stale", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
